// File: rtl/altera_tse_reset_ctrl_lego.sv
// Reset sequencer: hold reset, wait for rdone, delay, then flag sdone.
// Define ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN to resynchronise rdone internally.
module altera_tse_reset_ctrl_lego #(
  parameter int reset_hold_til_rdone = 0,
  parameter int reset_hold_cycles    = 1,
  parameter int sdone_delay_cycles   = 0
) (
  input  logic clock,
  input  logic aclr,
  input  logic start,
  input  logic rdone,
  output logic reset,
  output logic sdone
);

  localparam int HOLD_MAX =
    (reset_hold_cycles > 1) ? reset_hold_cycles : 1;
  localparam int DLY_MAX =
    (sdone_delay_cycles > 1) ? sdone_delay_cycles : 1;
  localparam int HOLD_W = $clog2(HOLD_MAX) + 1;
  localparam int DLY_W  = $clog2(DLY_MAX) + 1;

  localparam logic [HOLD_W-1:0] HOLD_INIT =
    HOLD_W'(reset_hold_cycles);
  localparam logic [DLY_W-1:0] DLY_INIT =
    DLY_W'(sdone_delay_cycles);
  localparam logic RST_WAIT = (reset_hold_til_rdone != 0);
  localparam logic NO_DELAY = (sdone_delay_cycles == 0);

  typedef enum logic [1:0] {
    HOLD,
    WAIT_RDONE,
    DELAY,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_nxt;
  logic [HOLD_W-1:0] hold_dec;
  logic [DLY_W-1:0]  dly_q;
  logic [DLY_W-1:0]  dly_nxt;
  logic [DLY_W-1:0]  dly_dec;
  logic              reset_nxt;
  logic              sdone_nxt;
  logic              rdone_s;

`ifdef ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN
  logic [1:0] rdone_sync;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rdone_sync <= '0;
    end else begin
      rdone_sync <= {rdone_sync[0], rdone};
    end
  end

  assign rdone_s = rdone_sync[1];
`else
  assign rdone_s = rdone;
`endif

  // Counters saturate at zero rather than wrapping
  assign hold_dec = (hold_q == '0) ? '0 :
                    hold_q - HOLD_W'(1);
  assign dly_dec  = (dly_q == '0) ? '0 :
                    dly_q - DLY_W'(1);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= HOLD;
      hold_q  <= HOLD_INIT;
      dly_q   <= DLY_INIT;
      reset   <= 1'b1;
      sdone   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      hold_q  <= hold_nxt;
      dly_q   <= dly_nxt;
      reset   <= reset_nxt;
      sdone   <= sdone_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_q;
    dly_nxt   = dly_q;
    if (start) begin
      state_nxt = HOLD;
      hold_nxt  = HOLD_INIT;
      dly_nxt   = DLY_INIT;
    end else begin
      unique case (state_q)
        HOLD: begin
          hold_nxt = hold_dec;
          if (hold_dec == '0) begin
            state_nxt = WAIT_RDONE;
          end
        end
        WAIT_RDONE: begin
          dly_nxt = DLY_INIT;
          if (rdone_s) begin
            state_nxt = NO_DELAY ? DONE : DELAY;
          end
        end
        DELAY: begin
          if (!rdone_s) begin
            state_nxt = WAIT_RDONE;
            dly_nxt   = DLY_INIT;
          end else begin
            dly_nxt = dly_dec;
            if (dly_dec == '0) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_INIT;
        end
      endcase
    end
  end

  // Outputs are registered from the next state, so no input reaches a pin
  always_comb begin
    reset_nxt = 1'b1;
    sdone_nxt = 1'b0;
    unique case (state_nxt)
      HOLD: begin
        reset_nxt = 1'b1;
      end
      WAIT_RDONE, DELAY: begin
        reset_nxt = RST_WAIT;
      end
      DONE: begin
        reset_nxt = 1'b0;
        sdone_nxt = 1'b1;
      end
      default: begin
        reset_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_altera_tse_reset_ctrl_lego.sv
// Bench for altera_tse_reset_ctrl_lego: three configurations,
// directed scenarios plus random stimulus against a run-length model.
module tb_altera_tse_reset_ctrl_lego;

`ifdef ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam int HP[3] = '{3, 2, 5};
  localparam int TP[3] = '{0, 1, 1};
  localparam int DP[3] = '{0, 2, 4};

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       start = 1'b0;
  logic       rdone = 1'b0;
  logic [2:0] dut_reset;
  logic [2:0] dut_sdone;

  int vectors = 0;
  int miss = 0;

  int   hl[3] = '{3, 2, 5};
  int   run[3] = '{0, 0, 0};
  logic dn[3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0] rh = 2'b00;

  always #5 clk = ~clk;

  altera_tse_reset_ctrl_lego #(
    .reset_hold_til_rdone(0),
    .reset_hold_cycles(3),
    .sdone_delay_cycles(0)
  ) u_a (
    .clock(clk), .aclr(aclr), .start(start), .rdone(rdone),
    .reset(dut_reset[0]), .sdone(dut_sdone[0])
  );

  altera_tse_reset_ctrl_lego #(
    .reset_hold_til_rdone(1),
    .reset_hold_cycles(2),
    .sdone_delay_cycles(2)
  ) u_b (
    .clock(clk), .aclr(aclr), .start(start), .rdone(rdone),
    .reset(dut_reset[1]), .sdone(dut_sdone[1])
  );

  altera_tse_reset_ctrl_lego #(
    .reset_hold_til_rdone(1),
    .reset_hold_cycles(5),
    .sdone_delay_cycles(4)
  ) u_c (
    .clock(clk), .aclr(aclr), .start(start), .rdone(rdone),
    .reset(dut_reset[2]), .sdone(dut_sdone[2])
  );

  // Model: remaining hold cycles, then length of the current rdone run
  always @(posedge clk or posedge aclr) begin
    logic ruse;
    int   nrun;
    if (aclr) begin
      for (int i = 0; i < 3; i++) begin
        hl[i]  <= HP[i];
        run[i] <= 0;
        dn[i]  <= 1'b0;
      end
      rh <= 2'b00;
    end else begin
      ruse = (SL != 0) ? rh[1] : rdone;
      rh <= {rh[0], rdone};
      for (int i = 0; i < 3; i++) begin
        if (start) begin
          hl[i]  <= HP[i];
          run[i] <= 0;
          dn[i]  <= 1'b0;
        end else if (hl[i] > 0) begin
          hl[i] <= hl[i] - 1;
        end else if (!dn[i]) begin
          nrun = ruse ? run[i] + 1 : 0;
          run[i] <= nrun;
          if (nrun >= DP[i] + 1) dn[i] <= 1'b1;
        end
      end
    end
  end

  function automatic logic m_reset(input int i);
    return (hl[i] > 0) || (!dn[i] && (TP[i] != 0));
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut_reset[i] !== m_reset(i) ||
          dut_sdone[i] !== dn[i]) begin
        miss++;
        $display("FAIL model[%0d] t=%0t reset=%b want %b sdone=%b want %b",
                 i, $time, dut_reset[i], m_reset(i),
                 dut_sdone[i], dn[i]);
      end
    end
  end

  task automatic tick(input logic st, input logic rd);
    start = st;
    rdone = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  initial begin
    logic rd;
    #1;
    aclr = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("por_reset_a", dut_reset[0], 1'b1);
    chk("por_sdone_a", dut_sdone[0], 1'b0);
    chk("por_reset_c", dut_reset[2], 1'b1);

    aclr = 1'b0;
    tick(1'b0, 1'b0);
    chk("rel1_reset_a", dut_reset[0], 1'b1);
    tick(1'b0, 1'b0);
    chk("rel2_reset_a", dut_reset[0], 1'b1);
    tick(1'b0, 1'b0);
    chk("rel3_reset_a", dut_reset[0], 1'b0);
    chk("rel3_sdone_a", dut_sdone[0], 1'b0);
    for (int k = 1; k <= 1 + SL; k++) tick(1'b0, 1'b1);
    chk("wait_done_a", dut_sdone[0], 1'b1);

    // One-cycle start pulse, hold 3, rdone already high
    tick(1'b1, 1'b1);
    chk("p_start_reset", dut_reset[0], 1'b1);
    chk("p_start_sdone", dut_sdone[0], 1'b0);
    tick(1'b0, 1'b1);
    chk("p1_reset", dut_reset[0], 1'b1);
    tick(1'b0, 1'b1);
    chk("p2_reset", dut_reset[0], 1'b1);
    tick(1'b0, 1'b1);
    chk("p3_reset", dut_reset[0], 1'b0);
    chk("p3_sdone", dut_sdone[0], 1'b0);
    tick(1'b0, 1'b1);
    chk("p4_sdone", dut_sdone[0], 1'b1);

    // Hold-til-rdone, delay 2, rdone arrives late
    tick(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b0);
    chk("b_wait_reset", dut_reset[1], 1'b1);
    for (int k = 1; k <= 3 + SL; k++) begin
      tick(1'b0, 1'b1);
      chk("b_reset", dut_reset[1], (k < 3 + SL) ? 1'b1 : 1'b0);
      chk("b_sdone", dut_sdone[1], (k < 3 + SL) ? 1'b0 : 1'b1);
    end
    tick(1'b0, 1'b0);
    chk("b_sticky", dut_sdone[1], 1'b1);

    // Delay 4 interrupted by a one-cycle rdone drop
    tick(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("c_drop_reset", dut_reset[2], 1'b1);
    chk("c_drop_sdone", dut_sdone[2], 1'b0);
    for (int k = 1; k <= 5 + SL; k++) begin
      tick(1'b0, 1'b1);
      chk("c_sdone", dut_sdone[2], (k == 5 + SL) ? 1'b1 : 1'b0);
      chk("c_reset", dut_reset[2], (k == 5 + SL) ? 1'b0 : 1'b1);
    end

    // Start held high for 20 cycles
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 1'b1);
      chk("sh_reset_b", dut_reset[1], 1'b1);
      chk("sh_sdone_b", dut_sdone[1], 1'b0);
    end
    tick(1'b0, 1'b1);
    chk("sh1_reset_b", dut_reset[1], 1'b1);
    chk("sh1_reset_a", dut_reset[0], 1'b1);
    tick(1'b0, 1'b1);
    chk("sh2_sdone_b", dut_sdone[1], 1'b0);
    chk("sh2_reset_a", dut_reset[0], 1'b1);
    tick(1'b0, 1'b1);
    chk("sh3_reset_a", dut_reset[0], 1'b0);
    tick(1'b0, 1'b1);
    chk("sh4_sdone_a", dut_sdone[0], 1'b1);

    // Asynchronous clear while in DONE, no clock edge
    #3;
    aclr = 1'b1;
    #1;
    chk("aclr_reset_a", dut_reset[0], 1'b1);
    chk("aclr_sdone_a", dut_sdone[0], 1'b0);
    @(posedge clk);
    #1;
    tick(1'b0, 1'b1);
    aclr = 1'b0;
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);

    rd = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) rd = ~rd;
      if ($urandom_range(0, 249) == 0) begin
        #($urandom_range(1, 3));
        aclr = 1'b1;
        for (int k = 0; k < $urandom_range(1, 3); k++)
          tick($urandom_range(0, 1) == 0, rd);
        aclr = 1'b0;
      end
      tick($urandom_range(0, 24) == 0, rd);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end

endmodule

// File: doc/altera_tse_reset_ctrl_lego.md
ALTERA_TSE_RESET_CTRL_LEGO -- requirements
Module: altera_tse_reset_ctrl_lego

Interface
REQ-001 Parameter reset_hold_til_rdone, default 0: 1 = keep reset asserted until rdone has been seen and the sdone delay has elapsed.
REQ-002 Parameter reset_hold_cycles, default 1: minimum number of clock cycles reset stays asserted after start is last sampled high; legal range 1..65535.
REQ-003 Parameter sdone_delay_cycles, default 0: clock cycles between rdone being accepted and sdone rising; legal range 0..65535.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 aclr  input  1  asynchronous, active-high reset of the block.
REQ-006 start  input  1  level-sensitive sequence request; high restarts the sequence every cycle it is sampled.
REQ-007 rdone  input  1  reset-done qualifier from the controlled resource or the previous stage.
REQ-008 reset  output  1  registered reset output to the controlled resource.
REQ-009 sdone  output  1  registered "sequence done" status for the next stage or the user.

Function
REQ-010 The block SHALL use states HOLD, WAIT_RDONE, DELAY and DONE; reset and sdone SHALL be driven from flops with no combinational path from any input.
REQ-011 Start: any cycle start=1 SHALL force HOLD, reload the hold counter to reset_hold_cycles, and drive reset=1 and sdone=0 from the next edge, whatever the current state.
REQ-012 HOLD: reset=1, sdone=0; the counter decrements each cycle start=0; when it expires the state SHALL go to WAIT_RDONE, so reset is high exactly reset_hold_cycles cycles after a one-cycle start pulse.
REQ-013 WAIT_RDONE: reset = reset_hold_til_rdone ? 1 : 0, sdone=0; when rdone=1, go to DELAY, or to DONE if sdone_delay_cycles=0.
REQ-014 DELAY: reset as in WAIT_RDONE; count sdone_delay_cycles cycles of continuous rdone=1, then go to DONE; if rdone falls, return to WAIT_RDONE and reload the delay counter.
REQ-015 DONE: reset=0, sdone=1; sdone is sticky and ignores later rdone deassertion; only start or aclr leave DONE.
REQ-016 Latency, reset_hold_til_rdone=0, delay 0, rdone already 1: sdone SHALL rise exactly one cycle after reset falls.
REQ-017 Latency, reset_hold_til_rdone=1: reset and sdone SHALL transition on the same edge, with reset falling and sdone rising sdone_delay_cycles+1 cycles after rdone is first sampled high.
REQ-018 Counter widths SHALL be clog2(max(param,1))+1 bits; counters SHALL saturate at zero and never wrap.
REQ-019 start and rdone both high in the same cycle: start wins (REQ-011).

Reset
REQ-020 aclr=1 SHALL immediately and asynchronously force reset=1, sdone=0, state HOLD and hold counter = reset_hold_cycles.
REQ-021 After aclr falls, the block SHALL run the HOLD sequence without needing a start pulse.
REQ-022 aclr asserted mid-sequence SHALL abort the sequence with the same forced values.

Configuration
REQ-023 Macro ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN defined: rdone SHALL pass through an internal two-flop synchronizer (altera_tse_xcvr_resync style, cleared by aclr) before use, adding 2 cycles to every rdone-dependent latency.
REQ-024 Macro ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN undefined: rdone SHALL be used directly, and must already be synchronous to clock.

Verification
REQ-025 hold=3, til_rdone=0, delay=0, rdone=1, one-cycle start -> reset=1 for 3 cycles, then 0; sdone=1 one cycle later.
REQ-026 til_rdone=1, delay=2, rdone raised 10 cycles after start -> reset stays 1 until 3 cycles after rdone rises, then reset=0 and sdone=1 on the same edge.
REQ-027 til_rdone=1, delay=4, rdone drops for 1 cycle during DELAY -> delay restarts; sdone rises 5 cycles after rdone returns.
REQ-028 start held high 20 cycles with hold=2 -> reset=1 throughout plus 2 cycles after start falls; sdone=0 throughout.
REQ-029 aclr pulse while in DONE -> reset=1 and sdone=0 immediately, with no clock edge; the sequence re-runs after release.
REQ-030 With ALTERA_TSE_RESET_CTRL_RDONE_SYNC_EN defined, REQ-025 stimulus with rdone raised after start -> sdone rises 2 cycles later than without the macro.
